led_band_mem_writer: RTL
========================

LED_BAND_MEM_WRITER -- requirements
Module: led_band_mem_writer

Interface
REQ-001 SHALL have parameter W_ADDR_WIDTH, default 11, width of the memory write address.
REQ-002 SHALL have parameter W_DATA_WIDTH, default 128, width of the memory write word; must be a multiple of 8.
REQ-003 SHALL have parameter FRAME_WORDS, default 864, number of words per 2D cylinder frame (110592 bits / 128); must be <= 2**W_ADDR_WIDTH.
REQ-004 w_clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 frame_start  input  1  single-cycle pulse that arms capture of one frame.
REQ-007 in_data  input  8  pixel byte stream.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  block accepts a byte; transfer occurs when in_valid && in_ready.
REQ-010 w_addr  output  W_ADDR_WIDTH  memory word address.
REQ-011 w_data  output  W_DATA_WIDTH  packed memory word.
REQ-012 write  output  1  memory write strobe, one cycle per word.
REQ-013 busy  output  1  high in FILL and DONE.
REQ-014 frame_done  output  1  one-cycle pulse after the last word of a frame is written.

Function
REQ-015 SHALL implement FSM states IDLE, FILL and DONE.
REQ-016 IDLE: in_ready=0; frame_start -> FILL with byte lane=0 and word address=0.
REQ-017 FILL: in_ready=1; each accepted byte SHALL be stored in lane L, bits [8L+7:8L], with L starting at 0 and incrementing per byte, so that byte address word*16+L on the 8-bit read side returns it.
REQ-018 On the accepted byte that completes lane 15 (W_DATA_WIDTH/8-1), the next cycle SHALL present write=1, the full word on w_data, and the current word address on w_addr; lane SHALL wrap to 0 and address SHALL increment.
REQ-019 in_ready SHALL stay high across word boundaries; sustained throughput is one byte per cycle with no bubbles.
REQ-020 When the word written is FRAME_WORDS-1, the FSM SHALL go FILL -> DONE in the same cycle that write is asserted; in_ready=0 from that cycle on.
REQ-021 DONE: frame_done=1 for exactly one cycle, then -> IDLE.
REQ-022 frame_start in FILL SHALL restart the frame: partial word discarded, lane=0, address=0, no write issued for the partial word; a write already scheduled for the same cycle SHALL still be issued.
REQ-023 frame_start in DONE SHALL be ignored.
REQ-024 in_valid in IDLE or DONE SHALL not be consumed.
REQ-025 w_addr and w_data SHALL hold their last values when write=0.
REQ-026 The address counter SHALL never exceed FRAME_WORDS-1.

Reset
REQ-027 While rst=1 the block SHALL be in IDLE with lane=0, address=0, in_ready=0, write=0, busy=0, frame_done=0, w_addr=0, w_data=0.
REQ-028 rst asserted mid-frame SHALL abort immediately with no further write; after release the block SHALL wait for a new frame_start.

Configuration
REQ-029 Macro LED_BAND_WRITER_OVERRUN_EN: when defined, the block SHALL add output overrun (1 bit), a sticky flag set when in_valid=1 while in IDLE or DONE, and cleared by frame_start or rst.
REQ-030 Without LED_BAND_WRITER_OVERRUN_EN, the overrun port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 rst, frame_start, then 16 bytes 0x00..0x0F streamed back-to-back -> one cycle later write=1, w_addr=0, w_data=0x0F0E...0100 (byte 0x00 in bits [7:0]).
REQ-032 full frame of 13824 continuous bytes -> 864 writes at addresses 0..863, in_ready never drops before the last byte, frame_done pulses once two cycles after the last byte, then IDLE.
REQ-033 frame_start after 20 bytes (one word written, 4 bytes pending) -> no write for the partial word; the next 16 bytes are written to w_addr=0.
REQ-034 rst asserted after 100 bytes, released, then 16 bytes without frame_start -> no write and in_ready=0 throughout.
REQ-035 in_valid toggled 1/0 every cycle during FILL -> words still correctly packed; write occurs only after every 16th accepted byte.
REQ-036 with LED_BAND_WRITER_OVERRUN_EN, in_valid=1 in IDLE -> overrun=1 and it stays 1 until frame_start; without the macro the design compiles with no overrun port.

Source files
------------

// File: rtl/led_band_mem_writer.sv
// Packs an 8-bit pixel stream into W_DATA_WIDTH-bit memory words for one cylinder frame.
// Optional sticky overrun flag is built when LED_BAND_WRITER_OVERRUN_EN is defined.
module led_band_mem_writer #(
    parameter int unsigned W_ADDR_WIDTH = 11,
    parameter int unsigned W_DATA_WIDTH = 128,
    parameter int unsigned FRAME_WORDS  = 864
) (
    input  logic                    w_clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [W_ADDR_WIDTH-1:0] w_addr,
    output logic [W_DATA_WIDTH-1:0] w_data,
    output logic                    write,
    output logic                    busy,
    output logic                    frame_done
`ifdef LED_BAND_WRITER_OVERRUN_EN
    ,
    output logic                    overrun
`endif
);

    localparam int unsigned Lanes = W_DATA_WIDTH / 8;
    localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam logic [LaneW-1:0]        LastLane = LaneW'(Lanes - 1);
    localparam logic [W_ADDR_WIDTH-1:0] LastAddr = W_ADDR_WIDTH'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e                  state_q, state_d;
    logic [LaneW-1:0]        lane_q;
    logic [W_ADDR_WIDTH-1:0] addr_q;
    logic [W_DATA_WIDTH-1:0] word_q;
    logic [W_DATA_WIDTH-1:0] word_next;
    logic                    write_q;
    logic [W_ADDR_WIDTH-1:0] w_addr_q;
    logic [W_DATA_WIDTH-1:0] w_data_q;

    logic fill;
    logic accept;
    logic word_done;
    logic last_word;
    logic restart;

    assign fill      = (state_q == StFill);
    assign accept    = in_valid && fill;
    assign word_done = accept && (lane_q == LastLane);
    assign last_word = (addr_q == LastAddr);
    assign restart   = frame_start && (state_q != StDone);

    // Current word with the incoming byte merged into its lane.
    always_comb begin
        word_next = word_q;
        for (int unsigned l = 0; l < Lanes; l++) begin
            if (lane_q == LaneW'(l)) begin
                word_next[l*8 +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE spans the final write cycle, then the frame_done cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (frame_start) begin
                    state_d = StFill;
                end else if (word_done && last_word) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!write_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready   = fill;
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone) && !write_q;
        write      = write_q;
        w_addr     = w_addr_q;
        w_data     = w_data_q;
    end

    // A word completing in a restart cycle is still written; restart only drops partial bytes.
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            lane_q   <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            write_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            write_q <= word_done;
            if (word_done) begin
                w_addr_q <= addr_q;
                w_data_q <= word_next;
            end
            if (restart) begin
                lane_q <= '0;
                addr_q <= '0;
                word_q <= '0;
            end else if (accept) begin
                if (lane_q == LastLane) begin
                    lane_q <= '0;
                    word_q <= '0;
                    addr_q <= last_word ? '0 : addr_q + 1'b1;
                end else begin
                    lane_q <= lane_q + 1'b1;
                    word_q <= word_next;
                end
            end
        end
    end

`ifdef LED_BAND_WRITER_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (frame_start) begin
            overrun_q <= 1'b0;
        end else if (in_valid && !fill) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule
